// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: default pixel width, frame FSM states and a
// width helper that never returns zero.
package img_pkg;

    localparam int PIX_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } estado_t;

    // A single address still needs one bit, so $clog2 is clamped to 1.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/gerador_endereco_ampliacao.sv
// Address generator for nearest-neighbour up-scaling: walks the destination raster
// with nested counters so the source address needs no divide or multiply.
module gerador_endereco_ampliacao
    import img_pkg::*;
#(
    parameter int LARGURA = 4,
    parameter int ALTURA  = 4,
    parameter int FATOR   = 2,
    parameter int N_DST   = LARGURA * ALTURA * FATOR * FATOR,
    parameter int SRC_AW  = clog2_min1(LARGURA * ALTURA),
    parameter int DST_AW  = clog2_min1(N_DST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    input  logic              wr_step,
    output logic [SRC_AW-1:0] rd_addr,
    output logic [DST_AW-1:0] wr_addr,
    output logic              last
);

    localparam int FX_W = clog2_min1(FATOR);
    localparam int SX_W = clog2_min1(LARGURA);

    localparam logic [FX_W-1:0]   FX_MAX   = FX_W'(FATOR - 1);
    localparam logic [SX_W-1:0]   SX_MAX   = SX_W'(LARGURA - 1);
    localparam logic [SRC_AW-1:0] ROW_STEP = SRC_AW'(LARGURA);
    localparam logic [SRC_AW-1:0] ROW_LAST = SRC_AW'((ALTURA - 1) * LARGURA);
    localparam logic [DST_AW-1:0] DST_MAX  = DST_AW'(N_DST - 1);

    logic [FX_W-1:0]   fx;
    logic [FX_W-1:0]   fy;
    logic [SX_W-1:0]   sx;
    logic [SRC_AW-1:0] row_base;
    logic [DST_AW-1:0] wr_cnt;

    // fx repeats a source pixel horizontally, fy repeats a source row vertically.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fx       <= '0;
            fy       <= '0;
            sx       <= '0;
            row_base <= '0;
        end else if (clr) begin
            fx       <= '0;
            fy       <= '0;
            sx       <= '0;
            row_base <= '0;
        end else if (adv) begin
            if (fx == FX_MAX) begin
                fx <= '0;
                if (sx == SX_MAX) begin
                    sx <= '0;
                    if (fy == FX_MAX) begin
                        fy       <= '0;
                        row_base <= (row_base == ROW_LAST) ? '0 : row_base + ROW_STEP;
                    end else begin
                        fy <= fy + 1'b1;
                    end
                end else begin
                    sx <= sx + 1'b1;
                end
            end else begin
                fx <= fx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt <= '0;
        end else if (clr) begin
            wr_cnt <= '0;
        end else if (wr_step) begin
            wr_cnt <= (wr_cnt == DST_MAX) ? '0 : wr_cnt + 1'b1;
        end
    end

    assign rd_addr = row_base + SRC_AW'(sx);
    assign wr_addr = wr_cnt;
    assign last    = (fx == FX_MAX) && (sx == SX_MAX) && (fy == FX_MAX) && (row_base == ROW_LAST);

endmodule

// File: rtl/ampliacao_replicacao.sv
// Frame up-scaler: replicates each source pixel into a FATOR x FATOR block, one
// destination pixel per cycle, one frame per start pulse.
module ampliacao_replicacao
    import img_pkg::*;
#(
    parameter int LARGURA    = 4,
    parameter int ALTURA     = 4,
    parameter int FATOR      = 2,
    parameter int PIX_W      = PIX_W_DEF,
    parameter int NEW_LARG   = LARGURA * FATOR,
    parameter int NEW_ALTURA = ALTURA * FATOR,
    parameter int SRC_AW     = clog2_min1(LARGURA * ALTURA),
    parameter int DST_AW     = clog2_min1(NEW_LARG * NEW_ALTURA)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [SRC_AW-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              wr_en,
    output logic [DST_AW-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data
);

    localparam int N_DST = NEW_LARG * NEW_ALTURA;

    estado_t estado;
    logic    clr;
    logic    adv;
    logic    last;

    assign clr = (estado == IDLE) && start;
    assign adv = (estado == RUN);

    gerador_endereco_ampliacao #(
        .LARGURA (LARGURA),
        .ALTURA  (ALTURA),
        .FATOR   (FATOR),
        .N_DST   (N_DST),
        .SRC_AW  (SRC_AW),
        .DST_AW  (DST_AW)
    ) u_gerador (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .adv     (adv),
        .wr_step (wr_en),
        .rd_addr (rd_addr),
        .wr_addr (wr_addr),
        .last    (last)
    );

    // wr_en trails rd_en by one cycle, matching the source RAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            rd_en  <= 1'b0;
            wr_en  <= 1'b0;
        end else begin
            case (estado)
                IDLE: begin
                    done  <= 1'b0;
                    wr_en <= 1'b0;
                    if (start) begin
                        estado <= RUN;
                        busy   <= 1'b1;
                        rd_en  <= 1'b1;
                    end
                end
                RUN: begin
                    wr_en <= 1'b1;
                    if (last) begin
                        estado <= FLUSH;
                        rd_en  <= 1'b0;
                    end
                end
                FLUSH: begin
                    wr_en  <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    estado <= DONE;
                end
                DONE: begin
                    done   <= 1'b0;
                    estado <= IDLE;
                end
                default: begin
                    estado <= IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    rd_en  <= 1'b0;
                    wr_en  <= 1'b0;
                end
            endcase
        end
    end

    // Source data arrives exactly in the write cycle; gating keeps the bus at zero otherwise.
    assign wr_data = wr_en ? rd_data : '0;

endmodule

// File: tb/tb_ampliacao_replicacao.sv
// Scoreboard bench for the up-scaler: three configurations (4x4 x2, 4x4 x1, 3x2 x3).
module tb_ampliacao_replicacao;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, req);
        end
    endtask

    function automatic int src_idx(input int n, input int larg, input int fat);
        return ((n / (larg * fat)) / fat) * larg + (n % (larg * fat)) / fat;
    endfunction

    // ---------------- instance 0: 4x4, FATOR=2 ----------------
    logic       start0, busy0, done0, rd_en0, wr_en0;
    logic [3:0] rd_addr0;
    logic [5:0] wr_addr0;
    logic [7:0] rd_data0, wr_data0;
    logic [7:0] src0[16];
    logic [7:0] dst0[64];
    exp_t q0[$];
    int   prev0 = -1, wr_cnt0 = 0, done_cnt0 = 0, done_at0 = 0, t0_0 = 0;

    ampliacao_replicacao #(.LARGURA(4), .ALTURA(4), .FATOR(2), .PIX_W(8)) u0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0)
    );

    always @(posedge clk) if (rd_en0) rd_data0 <= src0[rd_addr0];

    // ---------------- instance 1: 4x4, FATOR=1 ----------------
    logic       start1, busy1, done1, rd_en1, wr_en1;
    logic [3:0] rd_addr1, wr_addr1;
    logic [7:0] rd_data1, wr_data1;
    logic [7:0] dst1[16];
    int   prev_rd1 = -1;
    exp_t q1[$];
    int   prev1 = -1, wr_cnt1 = 0, done_cnt1 = 0, done_at1 = 0, t0_1 = 0;

    ampliacao_replicacao #(.LARGURA(4), .ALTURA(4), .FATOR(1), .PIX_W(8)) u1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1)
    );

    always @(posedge clk) if (rd_en1) rd_data1 <= src0[rd_addr1];

    // ---------------- instance 2: 3x2, FATOR=3 ----------------
    logic       start2, busy2, done2, rd_en2, wr_en2;
    logic [2:0] rd_addr2;
    logic [5:0] wr_addr2;
    logic [7:0] rd_data2, wr_data2;
    logic [7:0] src2[6];
    logic [7:0] dst2[54];
    exp_t q2[$];
    int   prev2 = -1, wr_cnt2 = 0, done_cnt2 = 0, done_at2 = 0, t0_2 = 0;

    ampliacao_replicacao #(.LARGURA(3), .ALTURA(2), .FATOR(3), .PIX_W(8)) u2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2)
    );

    always @(posedge clk) if (rd_en2) rd_data2 <= src2[rd_addr2];

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            if (rd_en0 && int'(rd_addr0) >= 16) chk("rd0_range", int'(rd_addr0), 15);
            if (wr_en0) begin
                wr_cnt0++;
                dst0[wr_addr0] = wr_data0;
                if (prev0 >= 0) chk("wr0_incr", int'(wr_addr0), prev0 + 1);
                prev0 = int'(wr_addr0);
                if (q0.size() == 0) chk("wr0_unexpected", int'(wr_addr0), -1);
                else begin
                    e = q0.pop_front();
                    chk("wr0_addr", int'(wr_addr0), e.addr);
                    chk("wr0_data", int'(wr_data0), e.data);
                end
            end
            if (done0) begin
                done_cnt0++;
                done_at0 = cyc + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            if (rd_en1 && int'(rd_addr1) >= 16) chk("rd1_range", int'(rd_addr1), 15);
            if (wr_en1) begin
                wr_cnt1++;
                dst1[wr_addr1] = wr_data1;
                chk("wr1_eq_prev_rd", int'(wr_addr1), prev_rd1);
                if (prev1 >= 0) chk("wr1_incr", int'(wr_addr1), prev1 + 1);
                prev1 = int'(wr_addr1);
                if (q1.size() == 0) chk("wr1_unexpected", int'(wr_addr1), -1);
                else begin
                    e = q1.pop_front();
                    chk("wr1_addr", int'(wr_addr1), e.addr);
                    chk("wr1_data", int'(wr_data1), e.data);
                end
            end
            prev_rd1 = rd_en1 ? int'(rd_addr1) : -1;
            if (done1) begin
                done_cnt1++;
                done_at1 = cyc + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            if (rd_en2 && int'(rd_addr2) >= 6) chk("rd2_range", int'(rd_addr2), 5);
            if (wr_en2) begin
                wr_cnt2++;
                dst2[wr_addr2] = wr_data2;
                if (prev2 >= 0) chk("wr2_incr", int'(wr_addr2), prev2 + 1);
                prev2 = int'(wr_addr2);
                if (q2.size() == 0) chk("wr2_unexpected", int'(wr_addr2), -1);
                else begin
                    e = q2.pop_front();
                    chk("wr2_addr", int'(wr_addr2), e.addr);
                    chk("wr2_data", int'(wr_data2), e.data);
                end
            end
            if (done2) begin
                done_cnt2++;
                done_at2 = cyc + 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic to_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic start_pulse(input int which);
        @(negedge clk);
        case (which)
            0: begin
                prev0 = -1; wr_cnt0 = 0;
                for (int n = 0; n < 64; n++) q0.push_back('{n, int'(src0[src_idx(n, 4, 2)])});
                t0_0 = cyc + 1; start0 = 1'b1;
            end
            1: begin
                prev1 = -1; wr_cnt1 = 0;
                for (int n = 0; n < 16; n++) q1.push_back('{n, int'(src0[n])});
                t0_1 = cyc + 1; start1 = 1'b1;
            end
            default: begin
                prev2 = -1; wr_cnt2 = 0;
                for (int n = 0; n < 54; n++) q2.push_back('{n, int'(src2[src_idx(n, 3, 3)])});
                t0_2 = cyc + 1; start2 = 1'b1;
            end
        endcase
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int target);
        int cnt;
        for (int i = 0; i < 300; i++) begin
            cnt = (which == 0) ? done_cnt0 : (which == 1) ? done_cnt1 : done_cnt2;
            if (cnt >= target) break;
            @(negedge clk); #1;
        end
        cnt = (which == 0) ? done_cnt0 : (which == 1) ? done_cnt1 : done_cnt2;
        if (cnt < target) chk("done_timeout", cnt, target);
        repeat (4) @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int d;
        for (int i = 0; i < 16; i++) src0[i] = 8'(i + 1);
        for (int i = 0; i < 6; i++)  src2[i] = 8'(16 + 3 * i);
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_rd_en", int'(rd_en0), 0);
        chk("rst_wr_en", int'(wr_en0), 0);
        chk("rst_rd_addr", int'(rd_addr0), 0);
        chk("rst_wr_addr", int'(wr_addr0), 0);
        chk("rst_wr_data", int'(wr_data0), 0);
        @(negedge clk);
        rst = 1'b0;

        // frame at FATOR=2
        d = done_cnt0;
        start_pulse(0);
        wait_done(0, d + 1);
        chk("f0_done_cnt", done_cnt0 - d, 1);
        chk("f0_done_at", done_at0, t0_0 + 66);
        chk("f0_writes", wr_cnt0, 64);
        chk("f0_q_empty", q0.size(), 0);
        chk("f0_dst0", int'(dst0[0]), 1);
        chk("f0_dst1", int'(dst0[1]), 1);
        chk("f0_dst8", int'(dst0[8]), 1);
        chk("f0_dst9", int'(dst0[9]), 1);
        chk("f0_dst2", int'(dst0[2]), 2);
        chk("f0_dst63", int'(dst0[63]), 16);
        chk("f0_busy_idle", int'(busy0), 0);

        // start while busy and during DONE is ignored
        d = done_cnt0;
        start_pulse(0);
        to_cycle(t0_0 + 9);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        to_cycle(t0_0 + 65);
        chk("f1_done_vis", int'(done0), 1);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        chk("f1_done_cnt", done_cnt0 - d, 1);
        chk("f1_done_at", done_at0, t0_0 + 66);
        chk("f1_writes", wr_cnt0, 64);
        chk("f1_no_restart", int'(rd_en0), 0);
        chk("f1_busy", int'(busy0), 0);
        chk("f1_q_empty", q0.size(), 0);

        // asynchronous reset mid-frame, then a clean frame
        start_pulse(0);
        to_cycle(t0_0 + 19);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", int'(wr_en0), 0);
        chk("mid_rst_busy", int'(busy0), 0);
        chk("mid_rst_rd_en", int'(rd_en0), 0);
        q0.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        d = done_cnt0;
        start_pulse(0);
        wait_done(0, d + 1);
        chk("f2_done_at", done_at0, t0_0 + 66);
        chk("f2_writes", wr_cnt0, 64);
        chk("f2_q_empty", q0.size(), 0);
        chk("f2_dst63", int'(dst0[63]), 16);
        chk("f2_dst9", int'(dst0[9]), 1);

        // FATOR=1 copy
        d = done_cnt1;
        start_pulse(1);
        wait_done(1, d + 1);
        chk("c1_done_at", done_at1, t0_1 + 18);
        chk("c1_writes", wr_cnt1, 16);
        chk("c1_q_empty", q1.size(), 0);
        for (int i = 0; i < 16; i += 5) chk("c1_copy", int'(dst1[i]), i + 1);

        // 3x2 source, FATOR=3
        d = done_cnt2;
        start_pulse(2);
        wait_done(2, d + 1);
        chk("n2_done_at", done_at2, t0_2 + 56);
        chk("n2_writes", wr_cnt2, 54);
        chk("n2_q_empty", q2.size(), 0);
        chk("n2_dst8", int'(dst2[8]), 22);
        chk("n2_dst27", int'(dst2[27]), 25);
        chk("n2_dst53", int'(dst2[53]), 31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
